// File: rtl/voice_mixer.sv
// voice_mixer: sequential voice summer with master gain and output stage.
//
// Once per sample_tick the block snapshots every voice and the 9-bit gain.
// It accumulates one voice per clock through a single adder, scales the sum
// with a single multiplier, then shifts right and resizes into the output.
// The result is held on `out` and announced with a one-cycle `out_valid`.
//
// Build option:
//   MIXER_SATURATE_EN  defined   -> the final result is clamped to the signed
//                                   WIDTH-bit range.
//                      undefined -> the final result keeps its low WIDTH bits
//                                   (two's-complement wrap).
// Both builds use the same state sequence and the same latency.
//
// Timing (tick sampled at edge 0):
//   edges 1..N_VOICES : ACCUM, one voice added per edge
//   edge  N_VOICES+1  : SCALE, gain multiply
//   edge  N_VOICES+2  : SAT, out/out_valid registered
// A tick that arrives while the block is busy is dropped, and `overrun`
// pulses on the following cycle. This includes the SAT cycle.

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module voice_mixer #(
    parameter int N_VOICES   = `N_OSCILLATORS,
    parameter int WIDTH      = 24,
    parameter int GAIN_SHIFT = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sample_tick,
    input  logic [N_VOICES*WIDTH-1:0] voices,
    input  logic [31:0]               volume,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic                      overrun
);

    // ------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------
    // The accumulator grows by clog2(N_VOICES) bits, so the sum of all
    // voices cannot overflow.
    localparam int ACCW  = WIDTH + $clog2(N_VOICES);
    // The product needs 10 extra bits: a 9-bit unsigned gain plus a sign bit.
    localparam int PRODW = ACCW + 10;
    // The voice index keeps at least one bit, so a single-voice build
    // still elaborates.
    localparam int IDXW  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_VOICES - 1);

    // Output range limits at product width. They are used for clamping.
    localparam logic signed [PRODW-1:0] SAT_MAX =
        {{(PRODW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PRODW-1:0] SAT_MIN =
        {{(PRODW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;
    localparam logic [1:0] S_SAT   = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]                r_state;
    logic signed [WIDTH-1:0]   r_snap [0:N_VOICES-1];
    logic [8:0]                r_gain;
    logic signed [ACCW-1:0]    r_acc;
    logic [IDXW-1:0]           r_idx;
    logic signed [PRODW-1:0]   r_prod;
    logic [WIDTH-1:0]          r_out;
    logic                      r_out_valid;
    logic                      r_overrun;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0]   w_voice [0:N_VOICES-1];
    logic                      w_idle;
    logic                      w_accept;
    logic                      w_last_voice;
    logic signed [WIDTH-1:0]   w_sel_voice;
    logic signed [ACCW-1:0]    w_sel_ext;
    logic signed [ACCW-1:0]    w_acc_sum;
    logic signed [PRODW-1:0]   w_acc_ext;
    logic signed [PRODW-1:0]   w_gain_ext;
    logic signed [PRODW-1:0]   w_shifted;
    logic [WIDTH-1:0]          w_result;
    logic                      w_unused_volume;

    // Split the flat voice bus into individual signed samples.
    genvar gi;
    generate
        for (gi = 0; gi < N_VOICES; gi++) begin : g_voice_split
            assign w_voice[gi] = voices[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Only the low nine bits of the volume word act as gain.
    assign w_unused_volume = ^volume[31:9];

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle && sample_tick;
    assign w_last_voice = (r_idx == LAST_IDX);

    // One adder: the selected snapshot voice, sign-extended, plus the
    // running sum.
    assign w_sel_voice = r_snap[r_idx];
    assign w_sel_ext   = ACCW'(w_sel_voice);
    assign w_acc_sum   = r_acc + w_sel_ext;

    // One multiplier. The gain is zero-extended, so it always acts as a
    // positive scale factor.
    assign w_acc_ext  = PRODW'(r_acc);
    assign w_gain_ext = PRODW'($signed({1'b0, r_gain}));

    // The arithmetic shift floors toward negative infinity.
    assign w_shifted = r_prod >>> GAIN_SHIFT;

`ifdef MIXER_SATURATE_EN
    // Clamp to the signed WIDTH-bit range.
    always_comb begin
        w_result = w_shifted[WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_result = SAT_MAX[WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_result = SAT_MIN[WIDTH-1:0];
        end
    end
`else
    // Keep the low WIDTH bits, so out-of-range results wrap around.
    logic w_unused_shift_hi;
    logic w_unused_limits;
    assign w_unused_shift_hi = ^w_shifted[PRODW-1:WIDTH];
    assign w_unused_limits   = ^{SAT_MAX, SAT_MIN};
    assign w_result          = w_shifted[WIDTH-1:0];
`endif

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // State sequencing: IDLE -> ACCUM (N_VOICES cycles) -> SCALE -> SAT -> IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (sample_tick)  r_state <= S_ACCUM;
                S_ACCUM: if (w_last_voice) r_state <= S_SCALE;
                S_SCALE: r_state <= S_SAT;
                S_SAT:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Snapshot voices and gain on an accepted tick. Later input changes
    // cannot affect the sample in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_VOICES; i++) begin
                r_snap[i] <= '0;
            end
            r_gain <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N_VOICES; i++) begin
                r_snap[i] <= w_voice[i];
            end
            r_gain <= volume[8:0];
        end
    end

    // Accumulator and voice index: cleared on accept, one voice per ACCUM cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == S_ACCUM) begin
            r_acc <= w_acc_sum;
            if (!w_last_voice) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Gain multiply, registered once in SCALE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod <= '0;
        end else if (r_state == S_SCALE) begin
            r_prod <= w_acc_ext * w_gain_ext;
        end
    end

    // Output sample: updated only in SAT and held until the next SAT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else if (r_state == S_SAT) begin
            r_out <= w_result;
        end
    end

    // One-cycle flags: sample-ready pulse and dropped-tick pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_SAT);
            r_overrun   <= sample_tick && !w_idle;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Sums the signed outputs of all oscillators once per sample period, applies the master volume from `control_unit`, and presents one saturated sample per period to `dac_transmitter`. Sits between the oscillator bank and the DAC transmitter. Voices are accumulated sequentially, one per clock, so the block needs a single adder and a single multiplier.

## Interface

Parameters:
- `N_VOICES`, default `` `N_OSCILLATORS ``: number of voice inputs.
- `WIDTH`, default 24: sample width, signed two's complement.
- `GAIN_SHIFT`, default 8: right shift after gain multiply. With the default, gain 256 = unity.

Ports:
- `clk`  in  1  system clock (`sys_clk` domain).
- `rstn`  in  1  asynchronous active-low reset.
- `sample_tick`  in  1  one-cycle pulse per sample period, synchronous to `clk`.
- `voices`  in  `N_VOICES`×`WIDTH`  signed voice samples.
- `volume`  in  32  master volume word. Only `volume[8:0]` is used, as an unsigned gain from 0 to 511.
- `out`  out  `WIDTH`  signed mixed sample, held between updates.
- `out_valid`  out  1  one-cycle pulse when `out` updates.
- `overrun`  out  1  one-cycle pulse when a `sample_tick` is dropped.

## Operation

- States: IDLE, ACCUM, SCALE, SAT.
- **IDLE.** On `sample_tick`:
  - capture all `voices` into a snapshot register;
  - capture `volume[8:0]` into a gain register;
  - set `acc`=0 and `idx`=0;
  - go to ACCUM.
- **ACCUM.** Each cycle `acc += snap[idx]` and `idx++`. After the add with `idx`=`N_VOICES`-1, go to SCALE.
  - `acc` width is `WIDTH`+$clog2(`N_VOICES`), so the sum cannot overflow.
- **SCALE.** `prod <= acc * $signed({1'b0,gain})`.
  - `prod` width is the `acc` width + 10.
  - Go to SAT.
- **SAT.**
  - `out <= resize(prod >>> GAIN_SHIFT)`. The shift is arithmetic, so it floors toward negative infinity.
  - Set `out_valid`=1 for one cycle.
  - Return to IDLE.
- Inputs change freely after capture; they have no effect on the sample in progress.
- A `sample_tick` in any state other than IDLE is ignored, and `overrun` pulses for one cycle in the following cycle. The sample in progress is unaffected.
- A `sample_tick` in the same cycle as SAT→IDLE is an overrun. It is not accepted.
- Reset (async, any state):
  - state=IDLE; `out`=0; `out_valid`=0; `overrun`=0;
  - `acc`, `prod`, `idx`, snapshot and gain = 0.
- Reset mid-operation aborts the sample with no `out_valid`. The first tick after `rstn` deasserts is processed normally.

## Timing

- Tick sampled at edge 0. ACCUM runs on edges 1..`N_VOICES`. SCALE is at edge `N_VOICES`+1. `out`/`out_valid` are registered at edge `N_VOICES`+2.
- Latency is `N_VOICES`+2 cycles from tick to `out_valid`. The busy window is the same length.
- Minimum tick spacing is `N_VOICES`+3 cycles. At 384 `sys_clk` cycles per sample, `N_VOICES` must be ≤ 381.
- `out` is stable from the `out_valid` cycle until the next SAT. The transmitter can latch it at any point in the sample period.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `MIXER_SATURATE_EN` defined: the SAT result is clamped to [-2^(`WIDTH`-1), 2^(`WIDTH`-1)-1].
- `MIXER_SATURATE_EN` undefined: the SAT result is truncated to the low `WIDTH` bits, i.e. two's-complement wrap.
- Latency and the state sequence are identical in both builds.

## Test plan

All scenarios use `N_VOICES`=4, `WIDTH`=24, `GAIN_SHIFT`=8.

1. **Basic mix.** voices {1000, 2000, -500, 0}, `volume`=256, one tick → `out`=2500, and `out_valid` pulses exactly 6 cycles after the tick edge. `out` holds 2500 afterwards.
2. **Gain.** Same voices, `volume`=128 → 1250. `volume`=0 → 0. voices {-3,0,0,0} with `volume`=128 → -2 (floor). `volume`=0x0000_0380 uses gain 0x180=384, so voices {1000,0,0,0} → 1500.
3. **Saturation.**
   - Four voices at 0x7FFFFF, `volume`=256 → `out`=0x7FFFFF with `MIXER_SATURATE_EN`; 0xFFFFFC (wrap) without it.
   - Four voices at 0x800000 → 0x800000 with the macro; 0x000000 without it.
4. **Snapshot and overrun.**
   - Change `voices` and `volume` 1 cycle after a tick → `out` reflects the captured values only.
   - Tick again 3 cycles after the first → `overrun` pulses once; one `out_valid` only.
   - Tick 10 cycles after the first → processed normally.
5. **Reset mid-operation.** Assert `rstn`=0 during ACCUM → `out`=0 immediately, with no `out_valid`. Release, then tick with voices {1,1,1,1} and `volume`=256 → `out`=4 after 6 cycles.
